// File: rtl/conv3x3_systolic_array.sv
// 2x2 output-stationary systolic array computing a 3x3 valid correlation over a 4x4 image.
// Runs once after reset, then holds the four results.
module conv3x3_systolic_array #(
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [16*DW-1:0] zin,
    input  logic [9*DW-1:0]  filter,
    output logic [DW-1:0]    out_c_0,
    output logic [DW-1:0]    out_c_1,
    output logic [DW-1:0]    out_c_2,
    output logic [DW-1:0]    out_c_3,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StRun  = 3'd2,
        StDone = 3'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       t_q, t_d;
    logic [16*DW-1:0] z_q;
    logic [9*DW-1:0]  f_q;
    logic [DW-1:0]    w00_q, w01_q;
    logic [ACCW-1:0]  acc_q [4];
    logic [ACCW-1:0]  acc_d [4];
    logic [DW-1:0]    out_q [4];
    logic [DW-1:0]    out_d [4];
    logic [DW-1:0]    wt    [4];

    int unsigned r, c, tt, k, idx;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            StIdle: state_d = StLoad;
            StLoad: begin
                state_d = StRun;
                t_d     = 4'd0;
            end
            StRun: begin
                if (t_q == 4'd10) state_d = StDone;
                else              t_d     = t_q + 4'd1;
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Weights enter PE(0,0) straight from the latch and ripple right/down one PE per cycle.
    always_comb begin
        wt[0] = '0;
        if (state_q == StRun && t_q <= 4'd8) wt[0] = f_q[DW*t_q +: DW];
        wt[1] = w00_q;
        wt[2] = w00_q;
        wt[3] = w01_q;
    end

    always_comb begin
        r   = 0;
        c   = 0;
        k   = 0;
        idx = 0;
        tt  = 32'(t_q);
        for (int p = 0; p < 4; p++) begin
            acc_d[p] = acc_q[p];
            out_d[p] = out_q[p];
            r = 32'(p) / 2;
            c = 32'(p) % 2;
            if (state_q == StLoad) begin
                acc_d[p] = '0;
            end else if (state_q == StRun && tt >= r + c && tt - (r + c) <= 8) begin
                k   = tt - (r + c);
                idx = 4 * (r + k / 3) + c + k % 3;
                acc_d[p] = acc_q[p] + ACCW'(z_q[DW*idx +: DW]) * ACCW'(wt[p]);
            end
            if (state_q == StDone) out_d[p] = acc_q[p][DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            t_q     <= '0;
            z_q     <= '0;
            f_q     <= '0;
            w00_q   <= '0;
            w01_q   <= '0;
            for (int p = 0; p < 4; p++) begin
                acc_q[p] <= '0;
                out_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w00_q   <= wt[0];
            w01_q   <= w00_q;
            if (state_q == StLoad) begin
                z_q <= zin;
                f_q <= filter;
            end
            for (int p = 0; p < 4; p++) begin
                acc_q[p] <= acc_d[p];
                out_q[p] <= out_d[p];
            end
        end
    end

    assign out_c_0 = out_q[0];
    assign out_c_1 = out_q[1];
    assign out_c_2 = out_q[2];
    assign out_c_3 = out_q[3];
    assign state   = state_q;

endmodule

// File: tb/tb_conv3x3_systolic_array.sv
// Directed bench for conv3x3_systolic_array: power-up run, FSM trace, async reset,
// operand isolation after LOAD and a table of image/kernel vectors.
module tb_conv3x3_systolic_array;

    logic         clk;
    logic         rst;
    logic [127:0] zin;
    logic [71:0]  filter;
    logic [7:0]   out_c_0, out_c_1, out_c_2, out_c_3;
    logic [2:0]   state;

    int n_checks;
    int n_errors;

    conv3x3_systolic_array dut (
        .clk     (clk),
        .rst     (rst),
        .zin     (zin),
        .filter  (filter),
        .out_c_0 (out_c_0),
        .out_c_1 (out_c_1),
        .out_c_2 (out_c_2),
        .out_c_3 (out_c_3),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] z;
        logic [71:0]  f;
        logic [31:0]  y;   // {Y11, Y10, Y01, Y00}
    } vec_t;

    localparam logic [127:0] NomZ = 128'h03_02_04_04_05_07_06_03_04_01_02_02_02_00_07_01;
    localparam logic [71:0]  NomF = 72'h02_09_05_08_05_03_01_06_04;
    localparam logic [31:0]  NomY = {8'd155, 8'd176, 8'd176, 8'd153};

    vec_t vecs [4];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {out_c_3, out_c_2, out_c_1, out_c_0};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{"nominal",  NomZ, NomF, NomY};
        vecs[1] = '{"wrap",     {16{8'hff}}, {9{8'hff}}, {4{8'd9}}};
        vecs[2] = '{"identity", 128'h0f0e0d0c0b0a09080706050403020100,
                    72'h00_00_00_00_01_00_00_00_00, {8'd10, 8'd9, 8'd6, 8'd5}};
        vecs[3] = '{"ones_x2",  {16{8'h01}}, {9{8'h02}}, {4{8'd18}}};

        // Power-up run with rst never asserted.
        rst    = 1'b0;
        zin    = NomZ;
        filter = NomF;
        #1;
        check("pwrup_state", 32'(state), 32'd0);
        check("pwrup_outs", outs(), 32'd0);
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            check($sformatf("trace_e%0d", e), 32'(state),
                  (e == 1) ? 32'd1 : (e <= 12) ? 32'd2 : 32'd3);
            if (e == 13) check("outs_before_e14", outs(), 32'd0);
        end
        check("nominal_e14", outs(), NomY);
        tick(51);
        check("nominal_hold_state", 32'(state), 32'd3);
        check("nominal_hold_outs", outs(), NomY);

        // Operands changed during RUN must not affect the result.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_from_done_state", 32'(state), 32'd0);
        check("rst_from_done_outs", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        zin    = {$urandom, $urandom, $urandom, $urandom};
        filter = {8'($urandom), $urandom, $urandom};
        tick(10);
        check("opchange_result", outs(), NomY);

        // Async reset in the middle of RUN, then a full restart.
        zin    = NomZ;
        filter = NomF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        check("midrun_state_pre", 32'(state), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_state", 32'(state), 32'd0);
        check("midrun_rst_outs", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(14);
        check("midrun_restart", outs(), NomY);

        // Table of vectors; each starts from a reset taken in DONE.
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            zin    = vecs[v].z;
            filter = vecs[v].f;
            #1;
            rst = 1'b1;
            #1;
            check({vecs[v].name, "_rst_outs"}, outs(), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            tick(13);
            check({vecs[v].name, "_e13"}, outs(), 32'd0);
            tick(1);
            check({vecs[v].name, "_result"}, outs(), vecs[v].y);
            check({vecs[v].name, "_state"}, 32'(state), 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
